// File: rtl/ysyx_22050710_lsu_pkg.sv
// ysyx_22050710_lsu_pkg: shared FSM states, access size codes and lane mask tables for the LSU.
package ysyx_22050710_lsu_pkg;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP, S_DONE} state_e;
    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_D} size_e;

    localparam logic [3:0][7:0] SIZE_MASK  = {8'hFF, 8'h0F, 8'h03, 8'h01};
    localparam logic [3:0][2:0] ALIGN_MASK = {3'b111, 3'b011, 3'b001, 3'b000};

    // EXU MemOP pairs signed/unsigned variants, so bits [2:1] alone give the size
    function automatic size_e size_of(input logic [2:0] op);
        return size_e'(op[2:1]);
    endfunction

endpackage

// File: rtl/ysyx_22050710_lsu_lane.sv
// ysyx_22050710_lsu_lane: combinational byte-lane shifting, write mask and misalign detection.
module ysyx_22050710_lsu_lane
    import ysyx_22050710_lsu_pkg::*;
(
    input  logic [2:0]  op_i,
    input  logic [63:0] addr_i,
    input  logic [63:0] wdata_i,
    input  logic        we_i,
    input  logic [63:0] mem_rdata_i,
    input  logic [2:0]  chk_op_i,
    input  logic [2:0]  chk_off_i,
    output logic [63:0] mem_addr_o,
    output logic [63:0] mem_wdata_o,
    output logic [7:0]  mem_wmask_o,
    output logic [63:0] rdata_o,
    output logic        misalign_o
);
    size_e       sz;
    logic [5:0]  sh;
    logic [7:0]  bmask;
    logic [63:0] bitmask;

    assign sz    = size_of(op_i);
    assign sh    = {addr_i[2:0], 3'b000};
    assign bmask = SIZE_MASK[sz];

    for (genvar b = 0; b < 8; b++) begin : g_bm
        assign bitmask[8*b +: 8] = {8{bmask[b]}};
    end

    assign mem_addr_o  = {addr_i[63:3], 3'b000};
    assign mem_wdata_o = wdata_i << sh;
    assign mem_wmask_o = we_i ? bmask << addr_i[2:0] : 8'h00;
    assign rdata_o     = (mem_rdata_i >> sh) & bitmask;
    // checked on the live core request, before fields are captured
    assign misalign_o  = |(chk_off_i & ALIGN_MASK[size_of(chk_op_i)]);

endmodule

// File: rtl/ysyx_22050710_lsu.sv
// ysyx_22050710_lsu: single-outstanding load/store unit bridging the core to a req/gnt/rvalid memory port.
module ysyx_22050710_lsu
    import ysyx_22050710_lsu_pkg::*;
#(
    parameter int RESP_TIMEOUT = 255
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic        i_wen,
    input  logic        i_ren,
    input  logic [2:0]  i_MemOP,
    input  logic [63:0] i_addr,
    input  logic [63:0] i_wdata,
    output logic [63:0] o_rdata,
    output logic        o_done,
    output logic        o_err,
    output logic        o_mem_req,
    input  logic        i_mem_gnt,
    output logic        o_mem_we,
    output logic [63:0] o_mem_addr,
    output logic [63:0] o_mem_wdata,
    output logic [7:0]  o_mem_wmask,
    input  logic        i_mem_rvalid,
    input  logic [63:0] i_mem_rdata
);
    localparam int CW = $clog2(RESP_TIMEOUT + 1);

    state_e          state_q;
    logic [63:0]     addr_q, wdata_q, rdata_q, lane_rdata;
    logic [2:0]      op_q;
    logic            we_q, req_q, done_q, err_q, misalign;
    logic [CW-1:0]   cnt_q;

    ysyx_22050710_lsu_lane u_lane (
        .op_i        (op_q),
        .addr_i      (addr_q),
        .wdata_i     (wdata_q),
        .we_i        (we_q),
        .mem_rdata_i (i_mem_rdata),
        .chk_op_i    (i_MemOP),
        .chk_off_i   (i_addr[2:0]),
        .mem_addr_o  (o_mem_addr),
        .mem_wdata_o (o_mem_wdata),
        .mem_wmask_o (o_mem_wmask),
        .rdata_o     (lane_rdata),
        .misalign_o  (misalign)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            op_q    <= '0;
            we_q    <= 1'b0;
            req_q   <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
            cnt_q   <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: if (i_valid && (i_wen || i_ren)) begin
                    addr_q  <= i_addr;
                    op_q    <= i_MemOP;
                    wdata_q <= i_wdata;
                    we_q    <= i_wen;
                    if (misalign) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                        err_q   <= 1'b1;
                        rdata_q <= '0;
                    end else begin
                        state_q <= S_REQ;
                        req_q   <= 1'b1;
                    end
                end
                S_REQ: if (i_mem_gnt) begin
                    req_q   <= 1'b0;
                    cnt_q   <= '0;
                    state_q <= S_RESP;
                end
                S_RESP: if (i_mem_rvalid) begin
                    rdata_q <= lane_rdata;
                    err_q   <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= S_DONE;
                end else if (cnt_q == CW'(RESP_TIMEOUT - 1)) begin
                    rdata_q <= '0;
                    err_q   <= 1'b1;
                    done_q  <= 1'b1;
                    state_q <= S_DONE;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
                default: begin
                    err_q   <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign o_ready   = state_q == S_IDLE;
    assign o_mem_req = req_q;
    assign o_mem_we  = we_q;
    assign o_done    = done_q;
    assign o_err     = err_q;
    assign o_rdata   = rdata_q;

endmodule
